// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/busy/done handshake and operand/result bus for the
//               bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, borrow, overflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor, diff = a - b - b_in,
//               one bit per clock LSB first, with registered borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire                 clk,
    input  wire                 rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int              c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0]   r_part;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_overflow;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_ai;
    logic               w_bi;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_part_next;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_shift  = (r_state == S_SHIFT);
    assign w_last   = w_shift && (r_cnt == c_LAST);

    // Full-subtractor cell on the current LSBs and the registered borrow
    assign w_ai        = r_a[0];
    assign w_bi        = r_b[0];
    assign w_d         = w_ai ^ w_bi ^ r_br;
    assign w_br_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_part_next = {w_d, r_part};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode, purely from registered state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_SHIFT: bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Operand/partial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_part <= '0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_br   <= bus.b_in;
            r_cnt  <= '0;
            r_part <= '0;
        end else if (w_shift) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + c_CNT_W'(1);
            r_part <= w_part_next[WIDTH-1:1];
        end
    end

    // Results update only on the completion edge and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_diff     <= w_part_next;
            r_borrow   <= w_br_next;
            r_overflow <= r_br ^ w_br_next;
        end
    end

    assign bus.diff     = r_diff;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned and signed views
    task automatic model(input int unsigned a, input int unsigned b, input int unsigned bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int signed sa, sb, sd, full;
        full = int'(a) - int'(b) - int'(bin);
        d    = W'(full);
        bo   = (a < b + bin);
        sa   = (a >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
        sb   = (b >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
        sd   = sa - sb - int'(bin);
        ov   = (sd < -(2**(W-1))) || (sd > 2**(W-1) - 1);
    endtask

    task automatic check_result(input string tag, input int unsigned a, input int unsigned b,
                                input int unsigned bin);
        logic [W-1:0] ed;
        logic         eb, eo;
        model(a, b, bin, ed, eb, eo);
        check({tag, ".diff"},     32'(bus.diff),     32'(ed));
        check({tag, ".borrow"},   32'(bus.borrow),   32'(eb));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
    endtask

    // Launch one operation at a negedge and wait for done; optional noise
    // on start/operands while SHIFT runs must not disturb anything.
    task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                          input int unsigned bin, input bit noise);
        int           cyc;
        int           nbusy;
        logic [W-1:0] held;
        held      = bus.diff;
        bus.start = 1'b1;
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.b_in  = bin[0];
        @(negedge clk);
        bus.start = 1'b0;
        cyc   = 0;
        nbusy = 0;
        while (!bus.done && cyc < W + 4) begin
            if (bus.busy) nbusy++;
            if (bus.diff !== held) begin
                check({tag, ".hold"}, 32'(bus.diff), 32'(held));
                held = bus.diff;
            end
            if (noise) begin
                bus.start = 1'($urandom);
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.b_in  = 1'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'(W));
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(W));
        check_result(tag, a, b, bin);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int rmax;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check_result("rst", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic",   8'h35, 8'h12, 0, 1'b0);
        check("basic.val", 32'(bus.diff), 32'h23);
        run_op("neg",     8'h12, 8'h35, 0, 1'b0);
        check("neg.val", 32'(bus.diff), 32'hDD);
        run_op("ovf_pos", 8'h80, 8'h01, 0, 1'b0);
        run_op("ovf_neg", 8'h7F, 8'hFF, 0, 1'b0);
        run_op("bin",     8'h00, 8'h00, 1, 1'b1);
        check("bin.val", 32'(bus.diff), 32'hFF);

        // Asynchronous reset in the 4th SHIFT cycle
        bus.start = 1'b1;
        bus.a     = 8'h35;
        bus.b     = 8'h12;
        bus.b_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.done", 32'(bus.done), 32'd0);
        check_result("arst", 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) cyc++;
        end
        check("arst.no_done", 32'(cyc), 32'd0);
        run_op("post_rst", 8'h35, 8'h12, 0, 1'b0);

        // Back-to-back: new start during the DONE cycle
        bus.start = 1'b1;
        bus.a     = 8'h35;
        bus.b     = 8'h12;
        bus.b_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < W + 4) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b.first_lat", 32'(cyc), 32'(W));
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h07;
        bus.b_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < W + 6) begin
            if (bus.diff !== 8'h23) check("b2b.hold", 32'(bus.diff), 32'h23);
            cyc++;
            @(negedge clk);
        end
        check("b2b.spacing", 32'(cyc), 32'(W + 1));
        check("b2b.diff", 32'(bus.diff), 32'hFE);
        check("b2b.borrow", 32'(bus.borrow), 32'd1);
        @(negedge clk);

        // Randomized operations, half with input noise while shifting
        rmax = 24;
        for (int i = 0; i < rmax; i++) begin
            run_op($sformatf("rnd%0d", i), $urandom_range(0, 2**W - 1),
                   $urandom_range(0, 2**W - 1), $urandom_range(0, 1), 1'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
